mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Load/store initiator that sits between the CPU execute stage and the single-ported data memory. Accepts one byte or word load/store per request from the CPU using byte addresses, translates it into word-addressed memory-port cycles, splits unaligned word accesses into two memory cycles, and returns read data, zero- or sign-extended for byte loads. Honors the memory's `mem_wait` stall and reports completion with a one-cycle `done` pulse.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  1  CPU request strobe; sampled only when the block is accepting
- `we`  in  1  1 = store, 0 = load
- `byte_op`  in  1  1 = byte access, 0 = word access
- `sext`  in  1  byte loads only: 1 = sign-extend bit 7, 0 = zero-extend
- `addr`  in  16  byte address
- `wdata`  in  16  store data; byte stores use `wdata[7:0]`
- `rdata`  out  16  load result, registered
- `busy`  out  1  request in progress; new `req` is ignored
- `done`  out  1  one-cycle completion pulse
- `mem_en`  out  1  memory port enable
- `mem_we`  out  1  memory write enable
- `mem_byte_enable`  out  1  byte write
- `mem_byte_select`  out  1  byte lane: 1 = [15:8], 0 = [7:0]
- `mem_addr`  out  16  word address
- `mem_wdata`  out  16  memory write data; byte writes carry the byte in [7:0]
- `mem_rdata`  in  16  memory read data, valid the cycle after an accepted read
- `mem_wait`  in  1  memory stall; the issue cycle repeats while high

## Operation
- Byte lanes are little-endian. Byte address A maps to word `A>>1`. Lane `A[0]`: 0 = [7:0], 1 = [15:8].
- Loads always issue word reads with `mem_byte_enable=0`. Byte extraction and extension are done internally.
- Stores issue byte writes (`mem_byte_enable=1`) or word writes.
- States are IDLE, ISSUE1, READ1, ISSUE2, READ2, DONE.
- IDLE/DONE: if `req`, latch `we`/`byte_op`/`sext`/`addr`/`wdata` and go to ISSUE1; otherwise go to IDLE.
- ISSUE1/ISSUE2: `mem_en=1`, with `mem_*` driven for the phase.
  - `mem_wait=1`: hold all outputs and stay in the state.
  - Otherwise, a load goes to READn.
  - A store goes to ISSUE2 if it is a split access and this is phase 1; otherwise it goes to DONE.
- READn: `mem_en=0`. Capture `mem_rdata`. Go to ISSUE2 (split access, phase 1) or DONE.
- Split access: word op with `addr[0]=1`.
  - Phase 1 targets word `addr>>1`, lane [15:8]; this is the low result byte.
  - Phase 2 targets word `(addr+1)>>1`, lane [7:0]; this is the high result byte. `addr+1` wraps at 16 bits, so 0xFFFF goes to word 0.
  - Split store phase 1: `mem_wdata={8'h00,wdata[7:0]}`, `mem_byte_select=1`.
  - Split store phase 2: `mem_wdata={8'h00,wdata[15:8]}`, `mem_byte_select=0`.
- Aligned word: one phase, word `addr>>1`, `mem_wdata=wdata`.
- Byte store: one phase, `mem_byte_select=addr[0]`, `mem_wdata={8'h00,wdata[7:0]}`.
- Byte load: the selected lane, extended per `sext`.
- `rdata` updates only on the load's DONE entry. Stores leave `rdata` unchanged.
- `busy=1` in ISSUE1, READ1, ISSUE2, READ2. `done=1` only in DONE.
- `req` while `busy` is dropped. The CPU re-asserts it after `done`.
- `mem_addr` is zero-extended: `{1'b0, byte_addr[15:1]}`.

## Timing
- Reset: at a rising edge with `rst=1` the state goes to IDLE, all outputs go to 0 (`rdata=0`), and the latched request is discarded. If reset lands mid-operation, `mem_en` is low from the next cycle and no further phase issues.
- `req` is sampled at edge 0, and ISSUE1 occupies cycle 1.
- Latency from `req` edge to the `done` cycle, with no wait:
  - aligned store: 2
  - aligned or byte load: 3
  - split store: 3
  - split load: 5
- Each `mem_wait=1` cycle during an ISSUE state adds one cycle.
- `mem_rdata` is sampled exactly in the READn cycle.
- Back-to-back: `req` high during DONE is accepted, and ISSUE1 follows immediately. There are no idle bubbles.
- `done` is never high for two consecutive cycles unless two requests complete back-to-back.

## Test plan
- Aligned word store then load:
  - Stimulus: store addr 0x0010, data 0xBEEF; then load 0x0010.
  - Memory port: write word 0x0008, `mem_wdata`=0xBEEF.
  - Completion: `rdata`=0xBEEF at `done`; latencies 2 and 3.
- Byte loads with extension, memory word 0x0008 = 0x80FF:
  - load byte 0x0011, `sext`=1: 0xFF80
  - load byte 0x0011, `sext`=0: 0x0080
  - load byte 0x0010, `sext`=1: 0xFFFF
- Split access at 0x0013:
  - Store 0x1234: phase 1 is a byte write to word 0x0009 lane [15:8] with 0x34; phase 2 is a byte write to word 0x000A lane [7:0] with 0x12.
  - Loading 0x0013 returns 0x1234 after 5 cycles.
- Wrap at 0xFFFF:
  - Word store 0x5A6B to 0xFFFF: phase 1 goes to word 0x7FFF lane [15:8] with 0x6B; phase 2 goes to word 0x0000 lane [7:0] with 0x5A.
  - Loading it back returns 0x5A6B.
- `mem_wait` held 3 cycles during ISSUE1 of an aligned load: `mem_*` outputs stay stable; `done` comes 6 cycles after `req`.
- Reset and dropped requests:
  - `rst` asserted during READ1 of a split load: next cycle IDLE, `mem_en`=0, `rdata`=0, no `done`.
  - `req` pulsed while `busy`: ignored, with no extra `done`.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store initiator between the CPU execute stage and a single-ported word memory.
// Splits unaligned word accesses into two byte-lane phases and extends byte loads.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic        sext,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte_enable,
    output logic        mem_byte_select,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_wait
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue1,
        StRead1,
        StIssue2,
        StRead2,
        StDone
    } state_e;

    state_e      state_q;
    logic        we_q, byte_q, sext_q;
    logic [15:0] addr_q, wdata_q;
    logic [7:0]  lo_q;
    logic        split_q;

    logic        accepting;
    logic        s_we, s_byte, s_split, s_ph2;
    logic [15:0] s_addr, s_wdata;
    logic [14:0] s_word1;
    logic        iss_we, iss_be, iss_bs;
    logic [15:0] iss_addr, iss_wdata;
    logic [34:0] iss_bus;
    logic [7:0]  lane;
    logic [15:0] byte_res;

    assign split_q = ~byte_q & addr_q[0];

    // Memory-port drive for the phase about to be issued: phase 1 from the incoming
    // request when accepting, otherwise phase 2 of the latched request.
    always_comb begin
        accepting = ((state_q == StIdle) || (state_q == StDone)) && req;
        s_we      = accepting ? we      : we_q;
        s_byte    = accepting ? byte_op : byte_q;
        s_addr    = accepting ? addr    : addr_q;
        s_wdata   = accepting ? wdata   : wdata_q;
        s_ph2     = ~accepting;
        s_split   = ~s_byte & s_addr[0];
        s_word1   = s_addr[15:1] + 15'd1;
        iss_addr  = {1'b0, s_ph2 ? s_word1 : s_addr[15:1]};
        iss_we    = s_we;
        iss_be    = s_we & (s_byte | s_split);
        iss_bs    = 1'b0;
        iss_wdata = 16'h0000;
        if (s_we) begin
            if (s_byte) begin
                iss_bs    = s_addr[0];
                iss_wdata = {8'h00, s_wdata[7:0]};
            end else if (s_split) begin
                iss_bs    = ~s_ph2;
                iss_wdata = s_ph2 ? {8'h00, s_wdata[15:8]} : {8'h00, s_wdata[7:0]};
            end else begin
                iss_wdata = s_wdata;
            end
        end
        iss_bus  = {iss_we, iss_be, iss_bs, iss_addr, iss_wdata};
        lane     = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        byte_res = {{8{sext_q & lane[7]}}, lane};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            we_q            <= 1'b0;
            byte_q          <= 1'b0;
            sext_q          <= 1'b0;
            addr_q          <= 16'h0000;
            wdata_q         <= 16'h0000;
            lo_q            <= 8'h00;
            rdata           <= 16'h0000;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_en          <= 1'b0;
            mem_we          <= 1'b0;
            mem_byte_enable <= 1'b0;
            mem_byte_select <= 1'b0;
            mem_addr        <= 16'h0000;
            mem_wdata       <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    busy <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        byte_q  <= byte_op;
                        sext_q  <= sext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state_q <= StIssue1;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        {mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata} <= iss_bus;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StIssue1: begin
                    if (!mem_wait) begin
                        if (!we_q) begin
                            state_q <= StRead1;
                            mem_en  <= 1'b0;
                        end else if (split_q) begin
                            state_q <= StIssue2;
                            {mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata} <= iss_bus;
                        end else begin
                            state_q <= StDone;
                            mem_en  <= 1'b0;
                            mem_we  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                StRead1: begin
                    if (split_q) begin
                        lo_q    <= mem_rdata[15:8];
                        state_q <= StIssue2;
                        mem_en  <= 1'b1;
                        {mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata} <= iss_bus;
                    end else begin
                        rdata   <= byte_q ? byte_res : mem_rdata;
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StIssue2: begin
                    if (!mem_wait) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!we_q) begin
                            state_q <= StRead2;
                        end else begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                StRead2: begin
                    rdata   <= {mem_rdata[7:0], lo_q};
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    mem_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-addressed memory model,
// plus directed cases for split/wrap accesses, stalls, reset and dropped requests.
module tb_mem_ctrl;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, byte_op = 1'b0, sext = 1'b0;
    logic [15:0] addr = 16'h0000, wdata = 16'h0000;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, mem_en, mem_we, mem_byte_enable, mem_byte_select;
    logic        mem_wait = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_op(byte_op), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte_enable(mem_byte_enable),
        .mem_byte_select(mem_byte_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    logic [15:0] mem [0:32767];
    logic [7:0]  refb [0:65535];
    logic [15:0] ref_rdata = 16'h0000;
    logic [33:0] wlog[$];
    int          n_tests = 0, n_fail = 0;
    int          hold_n = 0, stall_cnt = 0, unstable = 0;
    bit          rnd_wait = 1'b0;
    logic        prev_w = 1'b0;
    logic [35:0] prev_bus = '0;

    // Word-wide slave memory: read data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (mem_en && !mem_wait) begin
            if (mem_we) begin
                wlog.push_back({mem_addr, mem_byte_enable, mem_byte_select, mem_wdata});
                if (!mem_byte_enable) mem[mem_addr[14:0]] <= mem_wdata;
                else if (mem_byte_select) mem[mem_addr[14:0]][15:8] <= mem_wdata[7:0];
                else mem[mem_addr[14:0]][7:0] <= mem_wdata[7:0];
            end else begin
                mem_rdata <= mem[mem_addr[14:0]];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (mem_en && hold_n > 0) begin
            mem_wait = 1'b1;
            hold_n--;
            stall_cnt++;
        end else if (mem_en && rnd_wait && $urandom_range(0, 3) == 0) begin
            mem_wait = 1'b1;
            stall_cnt++;
        end else begin
            mem_wait = 1'b0;
        end
    end

    // Port must hold steady across a stalled issue cycle.
    always @(posedge clk) begin
        if (prev_w && ({mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata}
                       != prev_bus)) unstable++;
        prev_w   <= mem_en && mem_wait;
        prev_bus <= {mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [15:0] a,
                            input logic be, input logic bs, input logic [15:0] d);
        if (wlog.size() > idx) begin
            check({tag, "_addr"}, wlog[idx][33:18], a);
            check({tag, "_be"}, wlog[idx][17], be);
            check({tag, "_bs"}, wlog[idx][16], bs);
            check({tag, "_wdata"}, wlog[idx][15:0], d);
        end else begin
            check({tag, "_present"}, wlog.size(), idx + 1);
        end
    endtask

    // Issues one request and returns in its done cycle so the next call is back-to-back.
    task automatic do_op(input string tag, input bit w, input bit b, input bit s,
                         input logic [15:0] a, input logic [15:0] d, input int pulse_cyc,
                         output int lat);
        int          n, base;
        bit          seen;
        logic [15:0] a1;
        a1 = a + 16'd1;
        wlog.delete();
        stall_cnt = 0;
        req = 1'b1; we = w; byte_op = b; sext = s; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        n = 1;
        seen = 1'b0;
        lat = 0;
        while (n <= 40) begin
            if (pulse_cyc != 0 && n == pulse_cyc) begin
                req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 16'h0000; wdata = 16'hDEAD;
            end else if (pulse_cyc != 0 && n == pulse_cyc + 1) begin
                req = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        check({tag, "_done"}, seen, 1);
        if (!seen) return;
        lat = n;
        base = (b || !a[0]) ? (w ? 2 : 3) : (w ? 3 : 5);
        check({tag, "_lat"}, n, base + stall_cnt);
        if (w) begin
            refb[a] = d[7:0];
            if (!b) refb[a1] = d[15:8];
        end else if (b) begin
            ref_rdata = {{8{s & refb[a][7]}}, refb[a]};
        end else begin
            ref_rdata = {refb[a1], refb[a]};
        end
        check({tag, "_rdata"}, rdata, ref_rdata);
        check({tag, "_nwr"}, wlog.size(), w ? ((b || !a[0]) ? 1 : 2) : 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [15:0] v, ra, rd;
        bit          rw, rb, rs;
        int          lat, extra;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            refb[2*i] = v[7:0];
            refb[2*i+1] = v[15:8];
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("st_al", 1, 0, 0, 16'h0010, 16'hBEEF, 0, lat);
        check("st_al_lat2", lat, 2);
        check_wr("st_al_w", 0, 16'h0008, 1'b0, 1'b0, 16'hBEEF);
        do_op("ld_al", 0, 0, 0, 16'h0010, 16'h0000, 0, lat);
        check("ld_al_beef", rdata, 16'hBEEF);
        check("ld_al_lat3", lat, 3);

        do_op("st_80ff", 1, 0, 0, 16'h0010, 16'h80FF, 0, lat);
        do_op("ldb_s1", 0, 1, 1, 16'h0011, 16'h0000, 0, lat);
        check("ldb_s1_val", rdata, 16'hFF80);
        do_op("ldb_s0", 0, 1, 0, 16'h0011, 16'h0000, 0, lat);
        check("ldb_s0_val", rdata, 16'h0080);
        do_op("ldb_lo", 0, 1, 1, 16'h0010, 16'h0000, 0, lat);
        check("ldb_lo_val", rdata, 16'hFFFF);

        do_op("st_split", 1, 0, 0, 16'h0013, 16'h1234, 0, lat);
        check_wr("split_p1", 0, 16'h0009, 1'b1, 1'b1, 16'h0034);
        check_wr("split_p2", 1, 16'h000A, 1'b1, 1'b0, 16'h0012);
        do_op("ld_split", 0, 0, 0, 16'h0013, 16'h0000, 0, lat);
        check("ld_split_val", rdata, 16'h1234);
        check("ld_split_lat5", lat, 5);

        do_op("st_wrap", 1, 0, 0, 16'hFFFF, 16'h5A6B, 0, lat);
        check_wr("wrap_p1", 0, 16'h7FFF, 1'b1, 1'b1, 16'h006B);
        check_wr("wrap_p2", 1, 16'h0000, 1'b1, 1'b0, 16'h005A);
        do_op("ld_wrap", 0, 0, 0, 16'hFFFF, 16'h0000, 0, lat);
        check("ld_wrap_val", rdata, 16'h5A6B);

        unstable = 0;
        hold_n = 3;
        do_op("ld_wait", 0, 0, 0, 16'h0010, 16'h0000, 0, lat);
        check("wait_lat6", lat, 6);
        check("wait_stable", unstable, 0);

        do_op("ld_pulse", 0, 0, 0, 16'h0010, 16'h0000, 2, lat);
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || mem_en) extra++;
        end
        check("pulse_extra", extra, 0);
        do_op("ld_w0", 0, 0, 0, 16'h0000, 16'h0000, 0, lat);

        req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h0013;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rdata = 16'h0000;
        check("mid_mem_en", mem_en, 0);
        check("mid_rdata", rdata, 16'h0000);
        check("mid_done", done, 0);
        check("mid_busy0", busy, 0);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || mem_en) extra++;
        end
        check("mid_quiet", extra, 0);

        rnd_wait = 1'b1;
        repeat (300) begin
            ra = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31))
                                             : 16'hFFF0 + 16'($urandom_range(0, 15));
            rd = 16'($urandom);
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            do_op("rnd", rw, rb, rs, ra, rd, 0, lat);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_wait = 1'b0;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
